// File: rtl/game_pkg.sv
// Shared game types and constants.
// Used by the launch sequencer and the game controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RELOAD,
    AIM,
    CHARGE,
    FLIGHT,
    SETTLE,
    EMPTY
  } launch_state_t;

  localparam int NUM_BIRDS = 5;
  localparam int ANGLE_W   = 4;
  localparam int POWER_W   = 4;
  localparam int BIRD_W    = 3;
  localparam int TIMER_W   = 8;

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down counter with a zero flag.
// Counts only on tick and stops at zero.
module frame_timer
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               resetN,
  input  logic               tick,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic [TIMER_W-1:0] count,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // load wins over a pending decrement
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && count_q != '0) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  // counter register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/bird_launch_sequencer.sv
// Shot sequencer: aim, charge, launch, flight, settle, reload.
// Drives angle/power to the bird mover and counts birds.
module bird_launch_sequencer
  import game_pkg::*;
#(
  parameter int ANGLE_MIN      = 0,
  parameter int ANGLE_MAX      = 8,
  parameter int ANGLE_INIT     = 4,
  parameter int POWER_MAX      = 15,
  parameter int CHARGE_DIV     = 2,
  parameter int SETTLE_FRAMES  = 30,
  parameter int RELOAD_FRAMES  = 15,
  parameter int FLIGHT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       game_active,
  input  logic       new_level,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_fire,
  input  logic       bird_disappear,
  output logic [3:0] angle,
  output logic [3:0] power,
  output logic       launch_pulse,
  output logic       bird_ready,
  output logic       bird_in_flight,
  output logic [2:0] birds_left,
  output logic       out_of_birds
);

  localparam logic [ANGLE_W-1:0] A_MIN  = ANGLE_W'(ANGLE_MIN);
  localparam logic [ANGLE_W-1:0] A_MAX  = ANGLE_W'(ANGLE_MAX);
  localparam logic [ANGLE_W-1:0] A_INIT = ANGLE_W'(ANGLE_INIT);
  localparam logic [POWER_W-1:0] P_MAX  = POWER_W'(POWER_MAX);
  localparam logic [BIRD_W-1:0]  B_FULL = BIRD_W'(NUM_BIRDS);
  localparam logic [TIMER_W-1:0] T_REL  = TIMER_W'(RELOAD_FRAMES);
  localparam logic [TIMER_W-1:0] T_SET  = TIMER_W'(SETTLE_FRAMES);
  localparam logic [TIMER_W-1:0] T_FLT  = TIMER_W'(FLIGHT_TIMEOUT);
  localparam logic [TIMER_W-1:0] T_DIV  = TIMER_W'(CHARGE_DIV);
  localparam logic [TIMER_W-1:0] T_DIV1 = TIMER_W'(CHARGE_DIV - 1);

  launch_state_t      state_q, state_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic [POWER_W-1:0] power_q, power_d;
  logic [BIRD_W-1:0]  birds_q, birds_d;
  logic               launch_q, launch_d;
  logic               armed_q, armed_d;
  logic               ready_q, ready_d;
  logic               flight_q, flight_d;
  logic               empty_q, empty_d;

  logic               t_load;
  logic [TIMER_W-1:0] t_val;
  logic [TIMER_W-1:0] t_cnt;
  logic               t_zero;

  frame_timer u_timer (
    .clk      (clk),
    .resetN   (resetN),
    .tick     (startOfFrame),
    .load     (t_load),
    .load_val (t_val),
    .count    (t_cnt),
    .zero     (t_zero)
  );

  // next-state, datapath and timer control
  always_comb begin
    state_d  = state_q;
    angle_d  = angle_q;
    power_d  = power_q;
    birds_d  = birds_q;
    launch_d = 1'b0;
    t_load   = 1'b0;
    t_val    = '0;
    if (!game_active) begin
      state_d = IDLE;
      power_d = '0;
    end else if (new_level) begin
      birds_d = B_FULL;
      state_d = RELOAD;
      t_load  = 1'b1;
      t_val   = T_REL;
    end else begin
      unique case (state_q)
        RELOAD: begin
          if (t_zero) begin
            angle_d = A_INIT;
            power_d = '0;
            state_d = AIM;
          end
        end
        AIM: begin
          if (startOfFrame) begin
            if (key_up && !key_down
                && angle_q != A_MAX) begin
              angle_d = angle_q + ANGLE_W'(1);
            end else if (key_down && !key_up
                && angle_q != A_MIN) begin
              angle_d = angle_q - ANGLE_W'(1);
            end
            if (key_fire && armed_q) begin
              power_d = POWER_W'(1);
              state_d = CHARGE;
              t_load  = 1'b1;
              t_val   = T_DIV1;
            end
          end
        end
        CHARGE: begin
          if (startOfFrame) begin
            if (!key_fire) begin
              launch_d = 1'b1;
              if (birds_q != '0) begin
                birds_d = birds_q - BIRD_W'(1);
              end
              state_d = FLIGHT;
              t_load  = 1'b1;
              t_val   = T_FLT;
            end else if (t_cnt <= TIMER_W'(1)) begin
              t_load = 1'b1;
              t_val  = T_DIV;
              if (power_q != P_MAX) begin
                power_d = power_q + POWER_W'(1);
              end
            end
          end
        end
        FLIGHT: begin
          if (bird_disappear || t_zero) begin
            state_d = SETTLE;
            t_load  = 1'b1;
            t_val   = T_SET;
          end
        end
        SETTLE: begin
          if (t_zero) begin
            if (birds_q == '0) begin
              state_d = EMPTY;
            end else begin
              state_d = RELOAD;
              t_load  = 1'b1;
              t_val   = T_REL;
            end
          end
        end
        default: begin
        end
      endcase
    end
    armed_d = 1'b0;
    if (state_q == AIM && state_d == AIM) begin
      armed_d = armed_q | (startOfFrame & ~key_fire);
    end
    ready_d  = (state_d == AIM) || (state_d == CHARGE);
    flight_d = (state_d == FLIGHT);
    empty_d  = (state_d == EMPTY);
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      angle_q  <= A_INIT;
      power_q  <= '0;
      birds_q  <= '0;
      launch_q <= 1'b0;
      armed_q  <= 1'b0;
      ready_q  <= 1'b0;
      flight_q <= 1'b0;
      empty_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      angle_q  <= angle_d;
      power_q  <= power_d;
      birds_q  <= birds_d;
      launch_q <= launch_d;
      armed_q  <= armed_d;
      ready_q  <= ready_d;
      flight_q <= flight_d;
      empty_q  <= empty_d;
    end
  end

  assign angle          = angle_q;
  assign power          = power_q;
  assign launch_pulse   = launch_q;
  assign bird_ready     = ready_q;
  assign bird_in_flight = flight_q;
  assign birds_left     = birds_q;
  assign out_of_birds   = empty_q;

endmodule

// File: tb/tb_bird_launch_sequencer.sv
// Bench for bird_launch_sequencer: directed shots plus
// random keys, checked every cycle against a frame model.
module tb_bird_launch_sequencer;

  localparam int A_MAX = 8;
  localparam int A_INI = 4;
  localparam int P_MAX = 15;
  localparam int DIV   = 2;
  localparam int SET_F = 30;
  localparam int REL_F = 15;
  localparam int FLT_F = 255;
  localparam int NB    = 5;

  localparam int M_IDLE   = 0;
  localparam int M_RELOAD = 1;
  localparam int M_AIM    = 2;
  localparam int M_CHARGE = 3;
  localparam int M_FLIGHT = 4;
  localparam int M_SETTLE = 5;
  localparam int M_EMPTY  = 6;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic sof = 1'b0;
  logic ga = 1'b0;
  logic nl = 1'b0;
  logic up = 1'b0;
  logic dn = 1'b0;
  logic fire = 1'b0;
  logic dis = 1'b0;
  logic [3:0] angle;
  logic [3:0] power;
  logic launch;
  logic ready;
  logic flight;
  logic [2:0] birds;
  logic oob;

  int n_checks = 0;
  int n_fail = 0;
  int launches = 0;

  int m_phase, m_angle, m_power, m_birds;
  int m_frames, m_held;
  bit m_armed, m_launch;

  always #5 clk = ~clk;

  bird_launch_sequencer dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (sof),
    .game_active    (ga),
    .new_level      (nl),
    .key_up         (up),
    .key_down       (dn),
    .key_fire       (fire),
    .bird_disappear (dis),
    .angle          (angle),
    .power          (power),
    .launch_pulse   (launch),
    .bird_ready     (ready),
    .bird_in_flight (flight),
    .birds_left     (birds),
    .out_of_birds   (oob)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = M_IDLE;
    m_angle  = A_INI;
    m_power  = 0;
    m_birds  = 0;
    m_frames = 0;
    m_held   = 0;
    m_armed  = 0;
    m_launch = 0;
  endtask

  task automatic model_step(input bit s, input bit g,
                            input bit n, input bit u,
                            input bit d, input bit f,
                            input bit di);
    m_launch = 0;
    if (!g) begin
      m_phase = M_IDLE;
      m_power = 0;
      m_armed = 0;
    end else if (n) begin
      m_birds  = NB;
      m_phase  = M_RELOAD;
      m_frames = 0;
      m_armed  = 0;
    end else begin
      case (m_phase)
        M_RELOAD: begin
          if (m_frames == REL_F) begin
            m_phase = M_AIM;
            m_angle = A_INI;
            m_power = 0;
            m_armed = 0;
          end else if (s) m_frames++;
        end
        M_AIM: begin
          if (s) begin
            if (u && !d && m_angle < A_MAX) m_angle++;
            if (d && !u && m_angle > 0) m_angle--;
            if (!f) m_armed = 1;
            else if (m_armed) begin
              m_phase = M_CHARGE;
              m_held  = 1;
              m_power = 1;
              m_armed = 0;
            end
          end
        end
        M_CHARGE: begin
          if (s) begin
            if (!f) begin
              m_launch = 1;
              m_birds--;
              m_phase  = M_FLIGHT;
              m_frames = 0;
            end else begin
              m_held++;
              m_power = 1 + m_held / DIV;
              if (m_power > P_MAX) m_power = P_MAX;
            end
          end
        end
        M_FLIGHT: begin
          if (di || m_frames == FLT_F) begin
            m_phase  = M_SETTLE;
            m_frames = 0;
          end else if (s) m_frames++;
        end
        M_SETTLE: begin
          if (m_frames == SET_F) begin
            m_phase  = (m_birds == 0) ? M_EMPTY : M_RELOAD;
            m_frames = 0;
          end else if (s) m_frames++;
        end
        default: begin
        end
      endcase
    end
  endtask

  always @(posedge clk) begin
    bit s_i, g_i, n_i, u_i, d_i, f_i, di_i, r_i;
    s_i = sof; g_i = ga; n_i = nl; u_i = up;
    d_i = dn; f_i = fire; di_i = dis; r_i = resetN;
    if (!r_i) model_reset();
    else model_step(s_i, g_i, n_i, u_i, d_i, f_i, di_i);
    #1;
    if (r_i) begin
      check("angle", angle, m_angle);
      check("power", power, m_power);
      check("launch_pulse", launch, m_launch);
      check("bird_ready", ready,
            m_phase == M_AIM || m_phase == M_CHARGE);
      check("bird_in_flight", flight, m_phase == M_FLIGHT);
      check("birds_left", birds, m_birds);
      check("out_of_birds", oob, m_phase == M_EMPTY);
      if (launch) launches++;
    end
  end

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      sof = 1'b1;
      @(negedge clk);
      sof = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic pulse_nl();
    nl = 1'b1;
    @(negedge clk);
    nl = 1'b0;
  endtask

  task automatic pulse_dis();
    dis = 1'b1;
    @(negedge clk);
    dis = 1'b0;
  endtask

  task automatic shoot(input int hold);
    fire = 1'b0; frames(1);
    fire = 1'b1; frames(hold);
    fire = 1'b0; frames(1);
  endtask

  initial begin
    int l0;
    repeat (3) @(negedge clk);
    check("rst_angle", angle, 4);
    check("rst_power", power, 0);
    check("rst_birds", birds, 0);
    check("rst_ready", ready, 0);
    check("rst_launch", launch, 0);
    check("rst_oob", oob, 0);
    resetN = 1'b1;
    @(negedge clk);

    ga = 1'b1;
    pulse_nl();
    frames(15);
    check("aim_ready", ready, 1);
    check("aim_angle", angle, 4);
    check("aim_birds", birds, 5);

    up = 1'b1; frames(6);
    check("angle_sat_hi", angle, 8);
    dn = 1'b1; frames(3);
    check("angle_both", angle, 8);
    up = 1'b0; dn = 1'b0;

    l0 = launches;
    fire = 1'b1; frames(10);
    fire = 1'b0; frames(1);
    check("shot1_power", power, 6);
    check("shot1_pulses", launches - l0, 1);
    check("shot1_birds", birds, 4);
    check("shot1_flight", flight, 1);

    pulse_dis();
    check("settle_noflight", flight, 0);
    fire = 1'b1;
    frames(30);
    frames(15);
    frames(5);
    check("held_fire_ready", ready, 1);
    check("held_fire_power", power, 0);
    fire = 1'b0; frames(1);
    fire = 1'b1; frames(40);
    fire = 1'b0; frames(1);
    check("shot2_power", power, 15);
    check("shot2_birds", birds, 3);

    pulse_dis();
    frames(30);
    for (int k = 0; k < 3; k++) begin
      frames(15);
      shoot(3);
      pulse_dis();
      frames(30);
    end
    check("empty_oob", oob, 1);
    check("empty_birds", birds, 0);
    check("empty_ready", ready, 0);

    pulse_nl();
    check("refill_birds", birds, 5);
    check("refill_oob", oob, 0);

    frames(15);
    fire = 1'b0; frames(1);
    fire = 1'b1; frames(4);
    l0 = launches;
    ga = 1'b0;
    @(negedge clk);
    check("abort_ready", ready, 0);
    check("abort_power", power, 0);
    fire = 1'b0; frames(3);
    check("abort_pulses", launches - l0, 0);
    check("abort_angle", angle, 4);
    check("abort_birds", birds, 5);

    ga = 1'b1;
    pulse_nl();
    frames(15);
    shoot(2);
    frames(254);
    check("timeout_before", flight, 1);
    frames(1);
    check("timeout_after", flight, 0);
    check("timeout_birds", birds, 4);

    pulse_nl();
    for (int c = 0; c < 8000; c++) begin
      sof = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0)
        up = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0)
        dn = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 5) == 0)
        fire = ($urandom_range(0, 1) == 1);
      dis = ($urandom_range(0, 40) == 0);
      nl = ($urandom_range(0, 600) == 0);
      if (ga && $urandom_range(0, 900) == 0) ga = 1'b0;
      else if (!ga && $urandom_range(0, 20) == 0) ga = 1'b1;
      @(negedge clk);
    end
    sof = 1'b0; nl = 1'b0; dis = 1'b0;
    up = 1'b0; dn = 1'b0; fire = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
